// File: rtl/qam_pkg.sv
// Constants shared by the QAM4 mapper and demapper: sample width, constellation
// amplitude, default weak-symbol threshold and the dibit encoding.
package qam_pkg;

    localparam int unsigned QAM_W          = 16;
    localparam int unsigned QAM_AMP        = 23170;
    localparam int unsigned THRESH_DEFAULT = 8192;

    // Bit 1 is the sign of I, bit 0 the sign of Q; a set bit means negative.
    typedef enum logic [1:0] {
        DibitPP = 2'b00,
        DibitPM = 2'b01,
        DibitMP = 2'b10,
        DibitMM = 2'b11
    } dibit_e;

    function automatic dibit_e slice_dibit(input logic i_neg, input logic q_neg);
        return dibit_e'({i_neg, q_neg});
    endfunction

endpackage

// File: rtl/qam4_demapper_if.sv
// Sample-in / byte-out stream bundle of the QAM4 demapper.
interface qam4_demapper_if #(
    parameter int unsigned W = 16
) ();

    logic                valid_qam;
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
    logic                ready_out;
    logic                valid_out;
    logic [7:0]          data_out;
    logic                weak_out;

    modport slave (
        input  valid_qam, i, q, ready_out,
        output valid_out, data_out, weak_out
    );

    modport master (
        output valid_qam, i, q, ready_out,
        input  valid_out, data_out, weak_out
    );

endinterface

// File: rtl/byte_fifo2.sv
// Two-entry first-word-fall-through FIFO of byte + weak flag. A push into a full
// FIFO is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module byte_fifo2 #(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       push_weak_i,
    input  logic       pop_ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       weak_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    logic [8:0] mem_q [2];
    logic [8:0] mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       pop, wr_en;

    always_comb begin
        empty_o  = (count_q == 2'd0);
        full_o   = (count_q == 2'd2);
        pop      = !empty_o && pop_ready_i;
        wr_en    = push_i && (!full_o || pop);
        drop_o   = push_i && full_o && !pop;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {push_weak_i, push_data_i};
        end
        wr_ptr_d = wr_ptr_q ^ wr_en;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, wr_en} - {1'b0, pop};
        valid_o  = !empty_o;
        {weak_o, data_o} = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= 2'(Depth));

endmodule

// File: rtl/qam4_demapper.sv
// QAM4 hard-decision demapper: slices I/Q signs into dibits, packs four per byte
// (first symbol in the MSBs) and queues bytes with a weak-symbol flag.
module qam4_demapper
    import qam_pkg::*;
#(
    parameter int unsigned W          = QAM_W,
    parameter logic [W-1:0] THRESH    = W'(THRESH_DEFAULT),
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sync_clr,
    output logic           overflow,
    qam4_demapper_if.slave bus
);

    // Magnitude with the most negative code saturated to the largest positive one.
    function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
        if (!x[W-1]) return x;
        if (x[W-2:0] == '0) return {1'b0, {(W-1){1'b1}}};
        return -x;
    endfunction

    logic       accept;
    logic       s1_valid_q, s1_valid_d;
    dibit_e     s1_dibit_q, s1_dibit_d;
    logic       s1_weak_q, s1_weak_d;
    logic [1:0] cnt_q, cnt_d;
    logic [5:0] shreg_q, shreg_d;
    logic       wacc_q, wacc_d;
    logic       overflow_q, overflow_d;
    logic [7:0] packed_byte;
    logic       packed_weak;
    logic       fifo_push, fifo_full, fifo_empty, fifo_drop;

    always_comb begin
        accept     = en && bus.valid_qam;
        s1_valid_d = accept;
        s1_dibit_d = s1_dibit_q;
        s1_weak_d  = s1_weak_q;
        if (accept) begin
            s1_dibit_d = slice_dibit(bus.i[W-1], bus.q[W-1]);
            s1_weak_d  = (sat_abs(bus.i) < THRESH) || (sat_abs(bus.q) < THRESH);
        end
    end

    // sync_clr outranks a dibit arriving from stage 1 in the same cycle.
    always_comb begin
        packed_byte = {shreg_q, s1_dibit_q};
        packed_weak = wacc_q | s1_weak_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        wacc_d      = wacc_q;
        fifo_push   = 1'b0;
        if (sync_clr) begin
            cnt_d   = 2'd0;
            shreg_d = '0;
            wacc_d  = 1'b0;
        end else if (s1_valid_q) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                fifo_push = 1'b1;
                shreg_d   = '0;
                wacc_d    = 1'b0;
            end else begin
                shreg_d = packed_byte[5:0];
                wacc_d  = packed_weak;
            end
        end
        overflow_d = overflow_q | fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dibit_q <= DibitPP;
            s1_weak_q  <= 1'b0;
            cnt_q      <= 2'd0;
            shreg_q    <= '0;
            wacc_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dibit_q <= s1_dibit_d;
            s1_weak_q  <= s1_weak_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            wacc_q     <= wacc_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    byte_fifo2 #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (fifo_push),
        .push_data_i(packed_byte),
        .push_weak_i(packed_weak),
        .pop_ready_i(bus.ready_out),
        .valid_o    (bus.valid_out),
        .data_o     (bus.data_out),
        .weak_o     (bus.weak_out),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop)
    );

    a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_drop |-> fifo_full);
    a_valid_matches_empty: assert property (@(posedge clk) disable iff (!rst_n)
        bus.valid_out == !fifo_empty);

endmodule

// File: tb/tb_qam4_demapper.sv
// Bench for qam4_demapper: directed scenarios plus randomized traffic checked
// against a symbol-list / byte-queue reference model.
module tb_qam4_demapper;
    import qam_pkg::*;

    localparam int AMP = int'(QAM_AMP);
    localparam int THR = int'(THRESH_DEFAULT);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sync_clr = 1'b0;
    logic overflow;

    qam4_demapper_if #(.W(16)) bus ();

    qam4_demapper #(.W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .overflow(overflow),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: symbols gathered per byte, bytes queued {weak, byte}.
    logic [2:0] m_part[$];
    logic [8:0] m_fifo[$];
    bit         m_ovf = 1'b0;
    bit         m_inflight = 1'b0;
    logic [2:0] m_sym = '0;

    function automatic logic [2:0] model_sym(input int si, input int sq);
        int ai, aq;
        ai = (si < 0) ? -si : si;
        aq = (sq < 0) ? -sq : sq;
        return {(ai < THR) || (aq < THR), si < 0, sq < 0};
    endfunction

    function automatic logic [8:0] pack_part();
        int  val;
        bit  w;
        val = 0;
        w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            val = val + int'(m_part[k][1:0]) * (4 ** (3 - k));
            w = w | m_part[k][2];
        end
        return {w, 8'(val)};
    endfunction

    function automatic int sym_i(input logic [7:0] b, input int k);
        return b[7-2*k] ? -AMP : AMP;
    endfunction

    function automatic int sym_q(input logic [7:0] b, input int k);
        return b[6-2*k] ? -AMP : AMP;
    endfunction

    task automatic model_clear();
        m_part.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        m_inflight = 1'b0;
    endtask

    // A sample accepted at one edge reaches the byte queue at the next edge.
    task automatic model_edge();
        bit         have;
        bit         pop;
        logic [8:0] nb;
        if (!rst_n) return;
        have = 1'b0;
        nb = '0;
        pop = (m_fifo.size() > 0) && bus.ready_out;
        if (sync_clr) begin
            m_part.delete();
        end else if (m_inflight) begin
            m_part.push_back(m_sym);
            if (m_part.size() == 4) begin
                nb = pack_part();
                m_part.delete();
                have = 1'b1;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (have) begin
            if (m_fifo.size() < 2) m_fifo.push_back(nb);
            else m_ovf = 1'b1;
        end
        m_inflight = en && bus.valid_qam;
        if (m_inflight) m_sym = model_sym(int'(bus.i), int'(bus.q));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_sym(input int si, input int sq);
        bus.valid_qam = 1'b1;
        bus.i = 16'(si);
        bus.q = 16'(sq);
        tick();
        bus.valid_qam = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) send_sym(sym_i(b, k), sym_q(b, k));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b1;
        sync_clr = 1'b0;
        bus.valid_qam = 1'b0;
        bus.ready_out = 1'b0;
        bus.i = '0;
        bus.q = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h want 00", bus.data_out);
        end
        total++;
        if (bus.weak_out !== 1'b0) begin
            bad++; $display("FAIL reset_weak: got %b want 0", bus.weak_out);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_clean();
        do_reset();
        bus.ready_out = 1'b1;
        send_sym(AMP, AMP);
        send_sym(-AMP, AMP);
        send_sym(AMP, -AMP);
        send_sym(-AMP, -AMP);
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL clean_early: got valid=%b want 0", bus.valid_out);
        end
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h27 || bus.weak_out !== 1'b0) begin
            bad++;
            $display("FAIL clean_byte: got v=%b d=%h w=%b want v=1 d=27 w=0",
                     bus.valid_out, bus.data_out, bus.weak_out);
        end
        tick();
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL clean_one_cycle: got valid=%b want 0", bus.valid_out);
        end
    endtask

    task automatic test_weak_edges();
        do_reset();
        bus.ready_out = 1'b1;
        send_sym(0, 5000);
        send_sym(-32768, -32768);
        send_sym(8191, -8192);
        send_sym(8192, 8192);
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 8'h34 || bus.weak_out !== 1'b1) begin
            bad++;
            $display("FAIL weak_byte: got v=%b d=%h w=%b want v=1 d=34 w=1",
                     bus.valid_out, bus.data_out, bus.weak_out);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[3];
        do_reset();
        for (int n = 0; n < 3; n++) b[n] = 8'($urandom);
        for (int n = 0; n < 3; n++) send_byte(b[n]);
        tick();
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b[0] || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold: got v=%b d=%h ovf=%b want v=1 d=%h ovf=1",
                     bus.valid_out, bus.data_out, overflow, b[0]);
        end
        bus.ready_out = 1'b1;
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b[1]) begin
            bad++;
            $display("FAIL ovf_second: got v=%b d=%h want v=1 d=%h",
                     bus.valid_out, bus.data_out, b[1]);
        end
        tick();
        total++;
        if (bus.valid_out !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drained: got v=%b ovf=%b want v=0 ovf=1", bus.valid_out, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] b[3];
        do_reset();
        for (int n = 0; n < 3; n++) b[n] = 8'($urandom);
        for (int n = 0; n < 3; n++) send_byte(b[n]);
        bus.ready_out = 1'b1;
        tick();
        bus.ready_out = 1'b0;
        total++;
        if (overflow !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== b[1]) begin
            bad++;
            $display("FAIL fullpop_head: got ovf=%b v=%b d=%h want ovf=0 v=1 d=%h",
                     overflow, bus.valid_out, bus.data_out, b[1]);
        end
        bus.ready_out = 1'b1;
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b[2]) begin
            bad++;
            $display("FAIL fullpop_tail: got v=%b d=%h want v=1 d=%h",
                     bus.valid_out, bus.data_out, b[2]);
        end
        tick();
        total++;
        if (bus.valid_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_end: got v=%b ovf=%b want v=0 ovf=0", bus.valid_out, overflow);
        end
    endtask

    task automatic test_sync_clr();
        logic [7:0] b;
        do_reset();
        bus.ready_out = 1'b1;
        // Clear while the second symbol is still in flight.
        send_sym(-AMP, AMP);
        send_sym(AMP, -AMP);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        b = 8'($urandom);
        send_byte(b);
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b) begin
            bad++;
            $display("FAIL sync_inflight: got v=%b d=%h want v=1 d=%h", bus.valid_out, bus.data_out, b);
        end
        // Clear after a settled partial of three symbols.
        send_sym(-AMP, -AMP);
        send_sym(-AMP, -AMP);
        send_sym(-AMP, -AMP);
        tick();
        tick();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        b = 8'($urandom);
        send_byte(b);
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b || bus.weak_out !== 1'b0) begin
            bad++;
            $display("FAIL sync_partial: got v=%b d=%h w=%b want v=1 d=%h w=0",
                     bus.valid_out, bus.data_out, bus.weak_out, b);
        end
    endtask

    task automatic test_reset_gating();
        logic [7:0] b;
        bit         seen;
        do_reset();
        for (int n = 0; n < 3; n++) send_byte(8'($urandom));
        tick();
        total++;
        if (bus.valid_out !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL gate_prefill: got v=%b ovf=%b want v=1 ovf=1", bus.valid_out, overflow);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.valid_out !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got v=%b ovf=%b want v=0 ovf=0", bus.valid_out, overflow);
        end
        model_clear();
        #2;
        rst_n = 1'b1;
        en = 1'b0;
        bus.ready_out = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_sym(-AMP, AMP);
            seen = seen | bus.valid_out;
        end
        tick();
        tick();
        seen = seen | bus.valid_out;
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL en_low: got valid seen=%b want 0", seen);
        end
        en = 1'b1;
        b = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            send_sym(sym_i(b, k), sym_q(b, k));
            repeat ($urandom_range(0, 3)) tick();
        end
        if (bus.valid_out !== 1'b1) tick();
        total++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== b) begin
            bad++;
            $display("FAIL gaps: got v=%b d=%h want v=1 d=%h", bus.valid_out, bus.data_out, b);
        end
    endtask

    task automatic test_random();
        int edge_vals[7] = '{-32768, -8192, -8191, 0, 8191, 8192, 32767};
        logic [8:0] head;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.valid_qam = ($urandom_range(0, 3) != 0);
            bus.ready_out = (c < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
            sync_clr = !bus.valid_qam && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.i = 16'(edge_vals[$urandom_range(0, 6)]);
                bus.q = 16'(edge_vals[$urandom_range(0, 6)]);
            end else begin
                bus.i = 16'($urandom);
                bus.q = 16'($urandom);
            end
            tick();
            total++;
            if (bus.valid_out !== (m_fifo.size() > 0)) begin
                bad++;
                $display("FAIL rand_valid@%0d: got %b want %b", c, bus.valid_out, m_fifo.size() > 0);
            end
            total++;
            if (overflow !== m_ovf) begin
                bad++; $display("FAIL rand_ovf@%0d: got %b want %b", c, overflow, m_ovf);
            end
            if (m_fifo.size() > 0) begin
                head = m_fifo[0];
                total++;
                if ({bus.weak_out, bus.data_out} !== head) begin
                    bad++;
                    $display("FAIL rand_head@%0d: got w=%b d=%h want w=%b d=%h",
                             c, bus.weak_out, bus.data_out, head[8], head[7:0]);
                end
            end
        end
        sync_clr = 1'b0;
        bus.valid_qam = 1'b0;
    endtask

    initial begin
        bus.valid_qam = 1'b0;
        bus.ready_out = 1'b0;
        bus.i = '0;
        bus.q = '0;
        test_reset();
        test_clean();
        test_weak_edges();
        test_overflow();
        test_full_pop();
        test_sync_clr();
        test_reset_gating();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qam4_demapper.md
Name: qam4_demapper

Overview:
- Receive-side counterpart of the QAM4 mapper. Takes equalised I/Q samples, makes a hard decision per symbol and recovers its dibit. Packs four dibits into a byte.
- Delivers bytes through a 2-entry output FIFO with a valid/ready handshake. Flags low-confidence symbols and FIFO overflow.
- Sits between the FFT/equaliser output and the descrambler/byte sink of the OFDM receive chain.

Parameters:
- W, 16, I/Q sample width (signed two's complement)
- THRESH, 16'd8192, magnitude below which a symbol is marked weak (nominal constellation amplitude is 23170)
- FIFO_DEPTH, 2, output FIFO entries (fixed at 2; the parameter exists only for assertion checks)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; a sample is accepted only when en && valid_qam
- valid_qam  in  1  input sample strobe, one symbol per cycle
- i  in  W  signed in-phase sample
- q  in  W  signed quadrature sample
- sync_clr  in  1  synchronous restart of byte packing (OFDM symbol boundary)
- ready_out  in  1  downstream can take a byte
- valid_out  out  1  FIFO head valid
- data_out  out  8  packed byte at FIFO head
- weak_out  out  1  at least one of the byte's four symbols was weak
- overflow  out  1  sticky; a completed byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear to 0 and the FIFO empties:
  - valid_out, data_out, weak_out, overflow
  - stage-1 registers
  - packer count and packer shift register
- Decision (stage 1), registered on a cycle where en && valid_qam:
  - dibit[1] = i[W-1] and dibit[0] = q[W-1], so 00 means (+,+), 10 means (-,+), 01 means (+,-), 11 means (-,-).
  - Zero counts as positive.
  - weak = (|i| < THRESH) || (|q| < THRESH).
  - |x| saturates: -32768 maps to 32767.
  - s1_valid is set for one cycle.
- Packing (stage 2):
  - A 2-bit count cnt tracks position in the byte.
  - When s1_valid, the dibit shifts into a byte register, first symbol landing in [7:6] and fourth in [1:0].
  - The weak bits are ORed into the byte's weak flag. cnt increments and wraps 3 to 0.
  - On the 4th dibit the completed byte and its weak flag are pushed to the FIFO.
- Latency: a 4th sample accepted at clock edge N is pushed at edge N+1. valid_out is high after edge N+1 if the FIFO was empty (first-word fall-through).
- sync_clr:
  - Clears cnt, the partial byte and the weak accumulator. It does not touch the FIFO or overflow.
  - If it coincides with s1_valid, the clear wins and that dibit is discarded.
  - An s1 sample in flight when sync_clr arrives is also discarded.
- FIFO:
  - Pop occurs when valid_out && ready_out.
  - Push and pop in the same cycle are always allowed, including when the FIFO is full; occupancy is unchanged.
  - If the FIFO is full, a push with no pop drops the new byte and sets overflow. overflow stays set until reset.
  - data_out and weak_out hold their value while valid_out && !ready_out.
  - When the FIFO is empty, data_out and weak_out hold their last value. They are don't-care for checking.
- en low: no samples are accepted and the packer state is frozen. The FIFO still drains on ready_out.
- Input gaps: valid_qam may drop at any cycle. A partial byte is held indefinitely.

Decomposition:
- Shared package qam_pkg holds:
  - the constellation amplitude constant 23170
  - the default THRESH
  - the dibit encoding constants
  - W
- The mapper is to be refactored to use the same package.
- One sub-module is natural: byte_fifo2, a 2-entry first-word-fall-through FIFO with push/pop, full/empty and a drop-on-full indication.
- The decision and packer logic stay inline.

Test Plan:
- Clean constellation: stream (+23170,+23170), (-23170,+23170), (+23170,-23170), (-23170,-23170) with ready_out=1. Expect data_out=8'b00_10_01_11=8'h27, weak_out=0, valid_out one cycle, two edges after the 4th sample.
- Weak and edge values: samples (0,5000), (-32768,-32768), (8191,-8192), (8192,8192). Expect dibits 00,11,01,00, so byte 8'h34. weak_out=1 (first and third symbols are weak, -32768 is not weak).
- Backpressure and overflow: ready_out=0, then send 12 symbols. Expect 3 bytes completed, the FIFO holding bytes 1 and 2, byte 3 dropped and overflow=1. Then raise ready_out: bytes 1 and 2 drain in order and overflow stays 1.
- Full with simultaneous pop: keep the FIFO full and assert ready_out on the cycle the next byte completes. Expect no drop, overflow=0 and correct byte order.
- sync_clr mid-byte: after 2 symbols assert sync_clr, then send 4 known symbols. The output byte contains only the 4 new dibits.
- Reset and gating: assert rst_n low with bytes in the FIFO; valid_out=0 immediately and overflow clears. With en=0, samples are ignored and no byte is produced. Inputs with valid_qam gaps still pack correctly.
